collatz_sweep: RTL and testbench



---
 rtl/collatz_pkg.sv | 24 ++
 rtl/collatz_iter.sv | 27 ++
 rtl/collatz_sweep.sv | 176 +++++++++++++++++
 tb/tb_collatz_sweep.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/collatz_pkg.sv
// Shared types and helpers for the Collatz sweep controller and its iterator.
package collatz_pkg;

    localparam int STEP_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        CMP  = 3'd3,
        FIN  = 3'd4
    } sweep_state_t;

    // One Collatz step at 34 bits so that callers can see whether 3n+1 overflowed.
    function automatic logic [33:0] collatz_next(input logic [31:0] n);
        logic [33:0] w;
        w = {2'b00, n};
        if (n[0]) begin
            return w + (w << 1) + 34'd1;
        end
        return w >> 1;
    endfunction

endpackage

// File: rtl/collatz_iter.sv
// Single Collatz iterator: go loads a start value, otherwise one step per cycle.
// The 32-bit state wraps when 3n+1 does not fit; overflow policy lives in the controller.
module collatz_iter
    import collatz_pkg::*;
(
    input  logic        clk,
    input  logic        go,
    input  logic [31:0] n,
    output logic [31:0] dout,
    output logic        at_one
);

    logic [31:0] dout_q;
    logic [33:0] nxt;

    // Next value of the sequence, full width.
    always_comb nxt = collatz_next(dout_q);

    // Load on go, otherwise advance the sequence by one step.
    always_ff @(posedge clk) begin
        dout_q <= go ? n : 32'(nxt);
    end

    assign dout   = dout_q;
    assign at_one = (dout_q == 32'd1);

endmodule

// File: rtl/collatz_sweep.sv
// Collatz sweep controller: runs one iterator over base .. base+count-1, tracking
// the longest trajectory (step count and start value) and a sticky step-cap flag.
// Optional feature macro: COLLATZ_OVERFLOW_DET_EN adds a sticky overflow output and
// aborts a value whose 3n+1 does not fit in 32 bits.
//
// Handshake: start is a one-cycle request honoured only while idle (busy=0 and
// done=0); base and count are captured on that same edge. done pulses for exactly
// one cycle when the sweep completes; results hold until the next accepted start.
module collatz_sweep
    import collatz_pkg::*;
#(
    parameter int          STEP_W    = STEP_W_DEF,
    parameter int unsigned MAX_STEPS = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       base,
    input  logic [15:0]       count,
    output logic              busy,
    output logic              done,
    output logic [31:0]       cur_n,
    output logic [STEP_W-1:0] max_steps,
    output logic [31:0]       max_n,
    output logic              timeout,
`ifdef COLLATZ_OVERFLOW_DET_EN
    output logic              overflow,
`endif
    output logic [2:0]        state_dbg
);

    localparam logic [STEP_W-1:0] STEP_CAP = STEP_W'(MAX_STEPS);

    sweep_state_t      state_q, state_d;
    logic [31:0]       cur_n_q, cur_n_d;
    logic [15:0]       rem_q, rem_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [STEP_W-1:0] max_steps_q, max_steps_d;
    logic [31:0]       max_n_q, max_n_d;
    logic              timeout_q, timeout_d;
    logic              excl_q, excl_d;   // current value is barred from the max
    logic              iter_go;
    logic [31:0]       iter_dout;
    logic              iter_at_one;
`ifdef COLLATZ_OVERFLOW_DET_EN
    logic              ovf_q, ovf_d;
    logic [33:0]       dout_next;

    // Full-width next value, used only to spot 3n+1 leaving 32 bits.
    always_comb dout_next = collatz_next(iter_dout);
`endif

    collatz_iter u_iter (
        .clk    (clk),
        .go     (iter_go),
        .n      (cur_n_q),
        .dout   (iter_dout),
        .at_one (iter_at_one)
    );

    // Next-state, datapath updates and iterator control.
    always_comb begin
        state_d     = state_q;
        cur_n_d     = cur_n_q;
        rem_d       = rem_q;
        steps_d     = steps_q;
        max_steps_d = max_steps_q;
        max_n_d     = max_n_q;
        timeout_d   = timeout_q;
        excl_d      = excl_q;
`ifdef COLLATZ_OVERFLOW_DET_EN
        ovf_d       = ovf_q;
`endif
        // Holding go during reset keeps the iterator in a defined load state.
        iter_go     = reset;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_n_d     = base;
                    rem_d       = count;
                    max_steps_d = '0;
                    max_n_d     = '0;
                    timeout_d   = 1'b0;
`ifdef COLLATZ_OVERFLOW_DET_EN
                    ovf_d       = 1'b0;
`endif
                    state_d     = (count == 16'd0) ? FIN : LOAD;
                end
            end
            LOAD: begin
                iter_go = 1'b1;
                steps_d = '0;
                excl_d  = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                if (iter_at_one) begin
                    state_d = CMP;
                end else if (iter_dout == 32'd0) begin
                    // Start value 0 never reaches 1; it stays at zero steps and cannot win.
                    state_d = CMP;
                end else if (steps_q == STEP_CAP) begin
                    timeout_d = 1'b1;
                    excl_d    = 1'b1;
                    state_d   = CMP;
`ifdef COLLATZ_OVERFLOW_DET_EN
                end else if (dout_next > 34'h0_FFFF_FFFF) begin
                    ovf_d   = 1'b1;
                    excl_d  = 1'b1;
                    state_d = CMP;
`endif
                end else begin
                    // The cap branch above stops the counter before it can wrap.
                    steps_d = steps_q + STEP_W'(1);
                end
            end
            CMP: begin
                if (!excl_q && (steps_q > max_steps_q)) begin
                    max_steps_d = steps_q;
                    max_n_d     = cur_n_q;
                end
                cur_n_d = cur_n_q + 32'd1;
                rem_d   = rem_q - 16'd1;
                state_d = (rem_q == 16'd1) ? FIN : LOAD;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_n_q     <= '0;
            rem_q       <= '0;
            steps_q     <= '0;
            max_steps_q <= '0;
            max_n_q     <= '0;
            timeout_q   <= 1'b0;
            excl_q      <= 1'b0;
`ifdef COLLATZ_OVERFLOW_DET_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_n_q     <= cur_n_d;
            rem_q       <= rem_d;
            steps_q     <= steps_d;
            max_steps_q <= max_steps_d;
            max_n_q     <= max_n_d;
            timeout_q   <= timeout_d;
            excl_q      <= excl_d;
`ifdef COLLATZ_OVERFLOW_DET_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign busy      = (state_q == LOAD) || (state_q == RUN) || (state_q == CMP);
    assign done      = (state_q == FIN);
    assign cur_n     = cur_n_q;
    assign max_steps = max_steps_q;
    assign max_n     = max_n_q;
    assign timeout   = timeout_q;
    assign state_dbg = state_q;
`ifdef COLLATZ_OVERFLOW_DET_EN
    assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_collatz_sweep.sv
// Bench for collatz_sweep: directed and random sweeps against a plain-arithmetic
// Collatz model; expected results are queued at start and checked at each done.
module tb_collatz_sweep;

    localparam int TB_MAX = 120;

    typedef struct {
        logic [15:0] max_steps;
        logic [31:0] max_n;
        logic [31:0] cur_end;
        logic        timeout;
        logic        ovf;
        int          lat;
        int          t0;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base = '0;
    logic [15:0] count = '0;
    logic        busy, done, timeout;
    logic [31:0] cur_n, max_n;
    logic [15:0] max_steps;
    logic [2:0]  state_dbg;
`ifdef COLLATZ_OVERFLOW_DET_EN
    logic        overflow;
`endif

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    collatz_sweep #(.STEP_W(16), .MAX_STEPS(TB_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base      (base),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .cur_n     (cur_n),
        .max_steps (max_steps),
        .max_n     (max_n),
        .timeout   (timeout),
`ifdef COLLATZ_OVERFLOW_DET_EN
        .overflow  (overflow),
`endif
        .state_dbg (state_dbg)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: walk every start value through the Collatz rules directly.
    function automatic exp_t model(input logic [31:0] b, input logic [15:0] c);
        exp_t e;
        logic [31:0] v;
        longint unsigned n;
        int s;
        bit excl;
        e.max_steps = '0; e.max_n = '0; e.timeout = 1'b0; e.ovf = 1'b0;
        e.lat = 0; e.t0 = 0;
        v = b;
        for (int i = 0; i < int'(c); i++) begin
            n = v; s = 0; excl = 0;
            while (1) begin
                if (n == 1 || n == 0) break;
                if (s == TB_MAX) begin e.timeout = 1'b1; excl = 1; break; end
`ifdef COLLATZ_OVERFLOW_DET_EN
                if ((n % 2 == 1) && (3 * n + 1 >= 64'h1_0000_0000)) begin
                    e.ovf = 1'b1; excl = 1; break;
                end
`endif
                if (n % 2 == 1) n = (3 * n + 1) % 64'h1_0000_0000;
                else n = n / 2;
                s++;
            end
            e.lat += s + 3;
            if (!excl && s > int'(e.max_steps)) begin
                e.max_steps = 16'(s);
                e.max_n = v;
            end
            v = v + 32'd1;
        end
        e.cur_end = v;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("max_steps", max_steps, e.max_steps);
                check("max_n", max_n, e.max_n);
                check("timeout", timeout, e.timeout);
                check("cur_n_end", cur_n, e.cur_end);
                check("latency", cyc - e.t0, e.lat);
                check("busy_in_fin", busy, 0);
`ifdef COLLATZ_OVERFLOW_DET_EN
                check("overflow", overflow, e.ovf);
`endif
            end
        end
    end

    // Driver: issue one sweep, optionally poke start while busy, wait for done.
    task automatic run_sweep(input logic [31:0] b, input logic [15:0] c, input bit poke);
        exp_t e;
        bit got;
        e = model(b, c);
        @(negedge clk);
        start = 1'b1; base = b; count = c;
        e.t0 = cyc + 1;
        exp_q.push_back(e);
        got = 0;
        for (int i = 0; i < e.lat + 50; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (poke && i == 4) begin
                start = 1'b1; base = $urandom(); count = 16'($urandom_range(1, 50));
            end
            if (poke && i == 5) start = 1'b0;
            #1;
            if (exp_q.size() == 0) begin got = 1; break; end
        end
        start = 1'b0;
        if (!got) begin
            check("done_within_budget", 0, 1);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        check("busy_after_done", busy, 0);
        check("hold_max_steps", max_steps, e.max_steps);
        check("hold_max_n", max_n, e.max_n);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cur_n", cur_n, 0);
        check("rst_max_steps", max_steps, 0);
        check("rst_max_n", max_n, 0);
        check("rst_timeout", timeout, 0);
        reset = 1'b0;

        // Directed sweeps.
        run_sweep(32'd1, 16'd1, 0);
        run_sweep(32'd1, 16'd10, 0);
        run_sweep(32'd27, 16'd1, 0);
        run_sweep(32'd6, 16'd1, 0);
        run_sweep(32'd129, 16'd2, 0);
        run_sweep(32'd5, 16'd0, 0);
        run_sweep(32'hFFFF_FFFF, 16'd2, 0);
        run_sweep(32'd1, 16'd10, 1);

        // Reset in the middle of a sweep: no done, results cleared.
        @(negedge clk);
        start = 1'b1; base = 32'd1; count = 16'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_busy_before_reset", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_max_steps", max_steps, 0);
        check("mid_rst_cur_n", cur_n, 0);
        check("mid_rst_done", done, 0);
        repeat (150) @(negedge clk);

        // Random sweeps.
        for (int k = 0; k < 20; k++) begin
            logic [31:0] b;
            logic [15:0] c;
            b = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 2000));
            c = 16'($urandom_range(1, 6));
            run_sweep(b, c, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
